// File: rtl/uart_mm_bridge_pkg.sv
// Shared constants and state encodings for the UART-to-memory-mapped bridge.
// Compile-time option UART_MM_BRIDGE_TIMEOUT_EN enables the inter-byte timeout in the top.
package uart_mm_bridge_pkg;

   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK  = 8'h06;
   localparam logic [7:0] RSP_NAK  = 8'h15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_ADDR,
      ST_GET_DATA,
      ST_BUS_WRITE,
      ST_BUS_READ,
      ST_CAPTURE,
      ST_SEND_RESP
   } state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_mm_bridge_serdes.sv
// 8N1 serializer/deserializer: 2-flop rx synchronizer, mid-bit sampling receiver,
// and a transmitter that accepts the next byte in the last stop-bit cycle (no idle gap).
module uart_serdes
   import uart_mm_bridge_pkg::*;
#(
   parameter int CYCLES_PER_BIT = 217
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_i,
   output logic       tx_o,
   output logic       rx_valid_o,
   output logic [7:0] rx_data_o,
   input  logic       tx_send_i,
   input  logic [7:0] tx_data_i,
   output logic       tx_ready_o
);

   localparam int CW = $clog2(CYCLES_PER_BIT + 1);
   localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CYCLES_PER_BIT / 2 - 1);

   logic            rx_s1_q, rx_s2_q, rx_prev_q, rx_valid_q;
   rx_state_t       rx_st_q;
   logic [CW-1:0]   rx_cnt_q;
   logic [2:0]      rx_bit_q;
   logic [7:0]      rx_shift_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_valid_q <= 1'b0;
         rx_st_q    <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_s1_q    <= rx_i;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         rx_valid_q <= 1'b0;
         case (rx_st_q)
            RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
               rx_st_q  <= RX_START;
               rx_cnt_q <= '0;
            end
            // A start bit that has gone high again by mid-bit is treated as a glitch.
            RX_START: if (rx_cnt_q == HALF) begin
               rx_cnt_q <= '0;
               rx_bit_q <= '0;
               rx_st_q  <= rx_s2_q ? RX_IDLE : RX_DATA;
            end else rx_cnt_q <= rx_cnt_q + 1'b1;
            RX_DATA: if (rx_cnt_q == LAST) begin
               rx_cnt_q   <= '0;
               rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
               else rx_bit_q <= rx_bit_q + 1'b1;
            end else rx_cnt_q <= rx_cnt_q + 1'b1;
            RX_STOP: if (rx_cnt_q == LAST) begin
               rx_cnt_q   <= '0;
               rx_st_q    <= RX_IDLE;
               rx_valid_q <= rx_s2_q;
            end else rx_cnt_q <= rx_cnt_q + 1'b1;
            default: rx_st_q <= RX_IDLE;
         endcase
      end
   end

   assign rx_valid_o = rx_valid_q;
   assign rx_data_o  = rx_shift_q;

   logic            tx_q, tx_busy_q;
   logic [CW-1:0]   tx_cnt_q;
   logic [3:0]      tx_bit_q;
   logic [8:0]      tx_shift_q;

   assign tx_ready_o = !tx_busy_q || (tx_cnt_q == LAST && tx_bit_q == 4'd9);
   assign tx_o       = tx_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tx_q       <= 1'b1;
         tx_busy_q  <= 1'b0;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '1;
      end else if (tx_send_i && tx_ready_o) begin
         tx_q       <= 1'b0;
         tx_busy_q  <= 1'b1;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= {1'b1, tx_data_i};
      end else if (tx_busy_q) begin
         if (tx_cnt_q == LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'd9) begin
               tx_busy_q <= 1'b0;
               tx_q      <= 1'b1;
            end else begin
               tx_bit_q   <= tx_bit_q + 1'b1;
               tx_q       <= tx_shift_q[0];
               tx_shift_q <= {1'b1, tx_shift_q[8:1]};
            end
         end else tx_cnt_q <= tx_cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/uart_mm_bridge.sv
// UART command bridge acting as memory-mapped bus initiator ('W' write / 'R' read frames).
// Define UART_MM_BRIDGE_TIMEOUT_EN to drop partial frames after TIMEOUT_CYCLES of line silence.
module uart_mm_bridge
   import uart_mm_bridge_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = 25000000,
   parameter int BAUD_RATE       = 115200,
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES  = 2500000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    uart_rx,
   output logic                    uart_tx,
   output logic                    readEnable,
   output logic                    writeEnable,
   output logic [DATA_WIDTH/8-1:0] writeByteEnable,
   output logic [ADDR_WIDTH-1:0]   address,
   output logic [DATA_WIDTH-1:0]   writeData,
   input  logic [DATA_WIDTH-1:0]   readData,
   output logic                    busy
);

   localparam int CYCLES_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
   localparam int NB = DATA_WIDTH / 8;
   localparam int NA = ADDR_WIDTH / 8;

   if ((DATA_WIDTH % 8) != 0 || (ADDR_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("uart_mm_bridge: widths must be byte multiples and TIMEOUT_CYCLES positive");
   end

   logic       rx_valid, tx_send, tx_ready, timeout_hit;
   logic [7:0] rx_byte, tx_byte;

   state_t                  state_q;
   logic                    is_write_q;
   logic [7:0]              cnt_q, rem_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q, resp_q;

   uart_serdes #(.CYCLES_PER_BIT(CYCLES_PER_BIT)) u_serdes (
      .clock      (clock),
      .reset      (reset),
      .rx_i       (uart_rx),
      .tx_o       (uart_tx),
      .rx_valid_o (rx_valid),
      .rx_data_o  (rx_byte),
      .tx_send_i  (tx_send),
      .tx_data_i  (tx_byte),
      .tx_ready_o (tx_ready)
   );

`ifdef UART_MM_BRIDGE_TIMEOUT_EN
   logic [31:0] to_cnt_q;
   logic        in_frame;
   assign in_frame = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) to_cnt_q <= '0;
      else if (!in_frame || rx_valid) to_cnt_q <= '0;
      else to_cnt_q <= to_cnt_q + 1'b1;
   end
   assign timeout_hit = in_frame && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // The first response byte is launched from BUS_WRITE/CAPTURE so its start bit follows immediately.
   always_comb begin
      tx_send = 1'b0;
      tx_byte = resp_q[DATA_WIDTH-1 -: 8];
      case (state_q)
         ST_IDLE: if (rx_valid && rx_byte != OP_WRITE && rx_byte != OP_READ) begin
            tx_send = 1'b1;
            tx_byte = RSP_NAK;
         end
         ST_BUS_WRITE: begin
            tx_send = 1'b1;
            tx_byte = RSP_ACK;
         end
         ST_CAPTURE: begin
            tx_send = 1'b1;
            tx_byte = readData[DATA_WIDTH-1 -: 8];
         end
         ST_SEND_RESP: tx_send = (rem_q != 8'd0);
         default: tx_send = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         is_write_q <= 1'b0;
         cnt_q      <= '0;
         rem_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         resp_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (rx_valid && (rx_byte == OP_WRITE || rx_byte == OP_READ)) begin
               is_write_q <= (rx_byte == OP_WRITE);
               cnt_q      <= '0;
               state_q    <= ST_GET_ADDR;
            end
            ST_GET_ADDR: if (rx_valid) begin
               addr_q <= ADDR_WIDTH'({addr_q, rx_byte});
               if (cnt_q == 8'(NA - 1)) begin
                  cnt_q   <= '0;
                  state_q <= is_write_q ? ST_GET_DATA : ST_BUS_READ;
               end else cnt_q <= cnt_q + 1'b1;
            end else if (timeout_hit) state_q <= ST_IDLE;
            ST_GET_DATA: if (rx_valid) begin
               wdata_q <= DATA_WIDTH'({wdata_q, rx_byte});
               if (cnt_q == 8'(NB - 1)) begin
                  cnt_q   <= '0;
                  state_q <= ST_BUS_WRITE;
               end else cnt_q <= cnt_q + 1'b1;
            end else if (timeout_hit) state_q <= ST_IDLE;
            ST_BUS_WRITE: begin
               rem_q   <= '0;
               state_q <= ST_SEND_RESP;
            end
            ST_BUS_READ: state_q <= ST_CAPTURE;
            ST_CAPTURE: begin
               resp_q  <= readData << 8;
               rem_q   <= 8'(NB - 1);
               state_q <= ST_SEND_RESP;
            end
            ST_SEND_RESP: if (tx_ready) begin
               if (rem_q == 8'd0) state_q <= ST_IDLE;
               else begin
                  rem_q  <= rem_q - 1'b1;
                  resp_q <= resp_q << 8;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign readEnable      = (state_q == ST_BUS_READ);
   assign writeEnable     = (state_q == ST_BUS_WRITE);
   assign writeByteEnable = {NB{state_q == ST_BUS_WRITE}};
   assign address         = addr_q;
   assign writeData       = wdata_q;
   assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_mm_bridge.sv
// Directed bench for uart_mm_bridge: drives host frames on uart_rx, models the bus, decodes uart_tx.
module tb_uart_mm_bridge;

   localparam int CPB = 16;
   localparam int TO  = 3000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        uart_rx = 1'b1;
   logic        uart_tx, readEnable, writeEnable, busy;
   logic [3:0]  writeByteEnable;
   logic [31:0] address, writeData, readData, rd_value;

   always #5 clock = ~clock;

   uart_mm_bridge #(
      .CLOCK_FREQUENCY (25000000),
      .BAUD_RATE       (1562500),
      .DATA_WIDTH      (32),
      .ADDR_WIDTH      (32),
      .TIMEOUT_CYCLES  (TO)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .uart_rx         (uart_rx),
      .uart_tx         (uart_tx),
      .readEnable      (readEnable),
      .writeEnable     (writeEnable),
      .writeByteEnable (writeByteEnable),
      .address         (address),
      .writeData       (writeData),
      .readData        (readData),
      .busy            (busy)
   );

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   always @(posedge clock) readData <= readEnable ? rd_value : 32'h0;

   int we_n = 0, re_n = 0, we_cyc = 0, wbe_bad = 0, idle_bad = 0, edge_n = 0;
   int edge_t [0:1023];
   logic [31:0] cap_waddr, cap_wdata, cap_raddr;
   logic [3:0]  cap_wbe;
   logic        tx_prev = 1'b1;
   bit          idle_win = 1'b0;

   always @(negedge clock) begin
      if (writeEnable === 1'b1) begin
         we_n      <= we_n + 1;
         we_cyc    <= cyc;
         cap_waddr <= address;
         cap_wdata <= writeData;
         cap_wbe   <= writeByteEnable;
      end
      if (readEnable === 1'b1) begin
         re_n      <= re_n + 1;
         cap_raddr <= address;
      end
      if (writeByteEnable !== 4'h0 && writeEnable !== 1'b1) wbe_bad <= wbe_bad + 1;
      if (idle_win && (uart_tx !== 1'b1 || readEnable !== 1'b0 || writeEnable !== 1'b0 || busy !== 1'b0))
         idle_bad <= idle_bad + 1;
      if (uart_tx !== tx_prev) begin
         if (edge_n < 1024) edge_t[edge_n] <= cyc;
         edge_n <= edge_n + 1;
      end
      tx_prev <= uart_tx;
   end

   logic [7:0] rxb [0:255];
   int rx_n = 0, tx_ferr = 0;

   initial begin : tx_decoder
      logic [7:0] sh;
      forever begin
         @(negedge clock);
         if (reset === 1'b1 && uart_tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clock);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clock);
               sh[i] = uart_tx;
            end
            repeat (CPB) @(negedge clock);
            if (uart_tx !== 1'b1) tx_ferr = tx_ferr + 1;
            rxb[rx_n[7:0]] = sh;
            rx_n = rx_n + 1;
         end
      end
   end

   int n_pass = 0, n_total = 0, rx_rd = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clock);
      end
      uart_rx = stop;
      repeat (CPB) @(negedge clock);
      uart_rx = 1'b1;
      if (!stop) repeat (2 * CPB) @(negedge clock);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
   endtask

   task automatic expect_bytes(input string tag, input int n, input logic [31:0] exp);
      int t;
      logic [7:0] idx;
      t = 0;
      while (rx_n < rx_rd + n && t < 2000) begin
         @(negedge clock);
         t++;
      end
      check({tag, "_count"}, rx_n - rx_rd, n);
      for (int i = 0; i < n; i++) begin
         idx = 8'(rx_rd + i);
         check($sformatf("%s_byte%0d", tag, i), {24'h0, rxb[idx]}, {24'h0, exp[8*(n-1-i) +: 8]});
      end
      rx_rd = rx_rd + n;
      repeat (CPB) @(negedge clock);
      check({tag, "_busy_after"}, {31'h0, busy}, 32'h0);
   endtask

   initial begin : watchdog
      #(800000 * 10);
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int w0, r0, e0;
      rd_value = 32'h0;
      repeat (5) @(negedge clock);
      check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
      check("rst_readEnable", {31'h0, readEnable}, 32'h0);
      check("rst_writeEnable", {31'h0, writeEnable}, 32'h0);
      check("rst_wbe", {28'h0, writeByteEnable}, 32'h0);
      check("rst_address", address, 32'h0);
      check("rst_writeData", writeData, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      reset = 1'b1;
      @(negedge clock);
      idle_win = 1'b1;
      repeat (1000) @(negedge clock);
      idle_win = 1'b0;
      check("idle_quiet", idle_bad, 0);

      // Write 0x000000AB to 0x90000020, expect ACK with exact bit widths.
      w0 = we_n; r0 = re_n; e0 = edge_n;
      send_byte(8'h57, 1'b1);
      send_word(32'h90000020);
      send_word(32'h000000AB);
      expect_bytes("wr_ack", 1, 32'h06);
      check("wr_we_pulses", we_n - w0, 1);
      check("wr_re_pulses", re_n - r0, 0);
      check("wr_address", cap_waddr, 32'h90000020);
      check("wr_data", cap_wdata, 32'h000000AB);
      check("wr_wbe", {28'h0, cap_wbe}, 32'hF);
      check("ack_start_latency", edge_t[e0] - we_cyc, 1);
      check("ack_low_run", edge_t[e0+1] - edge_t[e0], 2 * CPB);
      check("ack_high_run", edge_t[e0+2] - edge_t[e0+1], 2 * CPB);
      check("ack_low_run2", edge_t[e0+3] - edge_t[e0+2], 5 * CPB);

      // Read 0x90000014 returning 0x00000001.
      w0 = we_n; r0 = re_n; rd_value = 32'h00000001;
      send_byte(8'h52, 1'b1);
      send_word(32'h90000014);
      expect_bytes("rd1", 4, 32'h00000001);
      check("rd1_re_pulses", re_n - r0, 1);
      check("rd1_we_pulses", we_n - w0, 0);
      check("rd1_address", cap_raddr, 32'h90000014);

      // Unknown opcode gets NAK, then a read still works.
      w0 = we_n; r0 = re_n;
      send_byte(8'h41, 1'b1);
      expect_bytes("nak", 1, 32'h15);
      check("nak_we_pulses", we_n - w0, 0);
      check("nak_re_pulses", re_n - r0, 0);
      rd_value = 32'h12345678;
      send_byte(8'h52, 1'b1);
      send_word(32'h00000004);
      expect_bytes("rd2", 4, 32'h12345678);
      check("rd2_address", cap_raddr, 32'h00000004);
      check("rd2_re_pulses", re_n - r0, 1);

      // Framing error on the opcode byte is dropped silently.
      w0 = we_n; r0 = re_n; rd_value = 32'hCAFEF00D;
      send_byte(8'h57, 1'b0);
      check("badstop_idle", {31'h0, busy}, 32'h0);
      check("badstop_no_resp", rx_n - rx_rd, 0);
      send_byte(8'h52, 1'b1);
      send_word(32'h90000000);
      expect_bytes("rd3", 4, 32'hCAFEF00D);
      check("rd3_we_pulses", we_n - w0, 0);
      check("rd3_re_pulses", re_n - r0, 1);

      // Partial write frame followed by a long silence.
      w0 = we_n; r0 = re_n;
      send_byte(8'h57, 1'b1);
      send_byte(8'h90, 1'b1);
      repeat (TO + 200) @(negedge clock);
`ifdef UART_MM_BRIDGE_TIMEOUT_EN
      check("to_busy_dropped", {31'h0, busy}, 32'h0);
      check("to_we_pulses", we_n - w0, 0);
      check("to_no_resp", rx_n - rx_rd, 0);
      rd_value = 32'h0BADF00D;
      send_byte(8'h52, 1'b1);
      send_word(32'h90000008);
      expect_bytes("to_rd", 4, 32'h0BADF00D);
      check("to_rd_address", cap_raddr, 32'h90000008);
      check("to_rd_re_pulses", re_n - r0, 1);
`else
      check("partial_busy_held", {31'h0, busy}, 32'h1);
      check("partial_we_pulses", we_n - w0, 0);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h20, 1'b1);
      send_word(32'h000000AB);
      expect_bytes("partial_ack", 1, 32'h06);
      check("partial_we_done", we_n - w0, 1);
      check("partial_address", cap_waddr, 32'h90000020);
      check("partial_data", cap_wdata, 32'h000000AB);
      check("partial_re_pulses", re_n - r0, 0);
`endif

      check("tx_stop_bits", tx_ferr, 0);
      check("wbe_outside_write", wbe_bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_mm_bridge.md
# uart_mm_bridge

Debug/boot bridge that receives command frames on a UART line and issues the matching memory-mapped read/write transactions as bus initiator. It is the master-side counterpart of `mm_uart`. The bridge drives the `readEnable`/`writeEnable`/`address` port from which `mm_uart` and the memories respond, which lets a host PC load and inspect memory without a running core. It has an integrated 8N1 serializer/deserializer and sends a response frame back for every command.

## Interface
- `CLOCK_FREQUENCY`, 25000000: clock rate in Hz.
- `BAUD_RATE`, 115200: line rate. `CYCLES_PER_BIT = CLOCK_FREQUENCY/BAUD_RATE` (integer divide; 217 at the defaults).
- `DATA_WIDTH`, 32: bus data width. Must be a multiple of 8. `NB = DATA_WIDTH/8`.
- `ADDR_WIDTH`, 32: bus address width. Must be a multiple of 8. `NA = ADDR_WIDTH/8`.
- `TIMEOUT_CYCLES`, 2500000: inter-byte timeout (100 ms at the default clock).
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `uart_rx`  in  1  serial input; asynchronous to `clock`.
- `uart_tx`  out  1  serial output; idles high.
- `readEnable`  out  1  bus read strobe.
- `writeEnable`  out  1  bus write strobe.
- `writeByteEnable`  out  NB  byte lanes for a write.
- `address`  out  ADDR_WIDTH  bus address.
- `writeData`  out  DATA_WIDTH  bus write data.
- `readData`  in  DATA_WIDTH  bus read data; valid one cycle after `readEnable`.
- `busy`  out  1  high whenever the FSM is outside IDLE.

## Operation
- Frames are bytes sent MSB-first across multi-byte fields.
- Write frame: 0x57 ('W'), NA address bytes, NB data bytes. The bridge performs a bus write, then transmits ACK 0x06.
- Read frame: 0x52 ('R'), NA address bytes. The bridge performs a bus read, then transmits the NB bytes of `readData`, MSB first.
- Any other opcode in IDLE: the bridge transmits NAK 0x15 and stays in IDLE. There is no bus activity.
- FSM states and transitions:
  - IDLE goes to GET_ADDR on 'W' or 'R'.
  - GET_ADDR goes to GET_DATA ('W') or BUS_READ ('R') after NA bytes.
  - GET_DATA goes to BUS_WRITE after NB bytes.
  - BUS_WRITE goes to SEND_RESP.
  - BUS_READ goes to CAPTURE, then CAPTURE goes to SEND_RESP.
  - SEND_RESP returns to IDLE after the last response byte's stop bit completes.
- Rx path:
  - 2-flop synchronizer, then falling-edge detect.
  - Start bit is re-checked at `CYCLES_PER_BIT/2`. If the line is high at that point it is a glitch and the receiver returns to idle.
  - 8 data bits are sampled mid-bit, LSB first.
  - The stop bit must be 1. A 0 stop bit is a framing error and the byte is discarded silently; frame assembly state is unchanged.
- Tx path: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly `CYCLES_PER_BIT` cycles. Response bytes are sent back-to-back with no idle gap.
- Bytes received in BUS_*, CAPTURE or SEND_RESP are discarded. The host must wait for the complete response before sending the next command.
- `writeByteEnable` is all ones during BUS_WRITE and zero at all other times.

## Timing
- Reset values: `uart_tx`=1, `readEnable`=0, `writeEnable`=0, `writeByteEnable`=0, `address`=0, `writeData`=0, `busy`=0. Rx and Tx counters clear and the FSM enters IDLE.
- Reset asserted mid-frame or mid-transmit aborts immediately and `uart_tx` returns high. No partial bus cycle is issued.
- `writeEnable` is high for exactly one cycle, in BUS_WRITE.
- `readEnable` is high for exactly one cycle, in BUS_READ. `readData` is registered in CAPTURE, the following cycle.
- `address` and `writeData` are held stable from the end of frame assembly through the strobe cycle.
- The first response start bit begins the cycle after BUS_WRITE or CAPTURE.
- A byte becomes valid 1 cycle after mid-stop-bit sampling. Synchronizer latency is 2 cycles.

## Configuration
- `UART_MM_BRIDGE_TIMEOUT_EN` defined:
  - A counter runs in GET_ADDR and GET_DATA and clears on each accepted byte.
  - When it reaches `TIMEOUT_CYCLES`, the FSM drops the partial frame and returns to IDLE with no response and no bus activity.
- Not defined: no counter. A partial frame waits indefinitely for its remaining bytes.

## Structure
- Shared package `uart_mm_bridge_pkg` holds:
  - opcode constants `OP_WRITE`=0x57 and `OP_READ`=0x52;
  - `RSP_ACK`=0x06 and `RSP_NAK`=0x15;
  - the FSM state encoding.
- One natural sub-module, `uart_serdes`. It contains the synchronizer and the Rx/Tx bit engines, parameterized by `CYCLES_PER_BIT`, with a byte-valid output and a byte-send/ready handshake. It is reusable by `mm_uart`.

## Test plan
- Reset, then idle for 1000 cycles: `uart_tx`=1, both strobes 0 and `busy`=0 throughout.
- Host sends 57 90 00 00 20 00 00 00 AB:
  - one-cycle `writeEnable` with `address`=0x90000020, `writeData`=0x000000AB, `writeByteEnable`=0xF;
  - then `uart_tx` emits 0x06 with bit width 217 cycles ±0.
- Host sends 52 90 00 00 14 and the bus model returns 0x00000001 one cycle after `readEnable`: exactly one `readEnable` pulse, then `uart_tx` emits 00 00 00 01.
- Host sends 0x41: `uart_tx` emits 0x15, no bus strobes occur, and a following valid read frame completes normally.
- Host sends 0x57 with the stop bit driven 0, then a valid read frame: the bad byte is ignored and the read completes.
- With `UART_MM_BRIDGE_TIMEOUT_EN`:
  - Host sends 57 90, then stays silent for >`TIMEOUT_CYCLES`: no bus cycle, `busy` falls, and a subsequent 'R' frame is processed correctly.
  - Without the macro, the same stimulus followed by the remaining 7 bytes completes the write.
